// File: rtl/moore_sched_pkg.sv
// ----------------------------------------------------------------------------
// moore_sched_pkg
// Shared definitions for the Moore detector scheduler: default sizing and the
// scheduler state encoding.
// Configuration macro: SCHED_PRIO_EN (consumed by rr_arbiter).
// ----------------------------------------------------------------------------
package moore_sched_pkg;

    localparam int DEF_N_REQ = 2;
    localparam int DEF_W     = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Picks one requester out of a request vector.
//   req_i  : per-requester request
//   ptr_i  : round-robin search start index
//   gnt_o  : one-hot grant (all zero when no request)
//   id_o   : encoded index of the granted requester
// Configuration macro: SCHED_PRIO_EN
//   defined   -> fixed priority, lowest index wins, ptr_i ignored
//   undefined -> round-robin, search starts at ptr_i and wraps to 0
// ----------------------------------------------------------------------------
module rr_arbiter
    import moore_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDW-1:0]   id_o
);

    logic found;

    // Round-robin as two passes: first the indices at or above the pointer,
    // then a plain low-to-high pass that covers the wrapped part.
    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        found = 1'b0;
`ifndef SCHED_PRIO_EN
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_i[i] && (i >= int'(ptr_i))) begin
                gnt_o[i] = 1'b1;
                id_o     = IDW'(i);
                found    = 1'b1;
            end
        end
`endif
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_i[i]) begin
                gnt_o[i] = 1'b1;
                id_o     = IDW'(i);
                found    = 1'b1;
            end
        end
    end

`ifdef SCHED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;
`endif

endmodule

// File: rtl/moore_det_scheduler.sv
// ----------------------------------------------------------------------------
// moore_det_scheduler
// Time-shares one serial Moore pattern detector between N_REQ requesters.
// A granted word is shifted into the detector MSB first after a detector
// clear; the detector's high samples are counted and returned with the id.
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active low
//   req_valid : per-requester word valid
//   req_data  : requester i word at [i*W +: W]
//   req_ready : one-cycle one-hot accept pulse
//   det_rst   : detector reset, active high, registered
//   det_in    : detector serial input, registered
//   det_out   : detector output
//   res_valid / res_ready / res_id / res_count : result handshake
// Configuration macro: SCHED_PRIO_EN (fixed priority instead of round-robin).
//
// state | meaning
// IDLE  | detector held in reset, waiting for any req_valid
// CLR   | word latched, req_ready pulsed, detector reset, counters cleared
// SHIFT | W cycles driving word bits MSB first, sampling det_out from bit 1
// DRAIN | detector reset released for one more sample after the last bit
// DONE  | result presented until res_ready, then pointer advances
// ----------------------------------------------------------------------------
module moore_det_scheduler
    import moore_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W,
    parameter int IDW   = $clog2(N_REQ),
    parameter int CW    = $clog2(W + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               det_rst,
    output logic               det_in,
    input  logic               det_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IDW-1:0]     res_id,
    output logic [CW-1:0]      res_count
);

    state_t           state_q, state_d;
    logic [W-1:0]     word_q, word_d, word_sel;
    logic [IDW-1:0]   id_q, id_d, ptr_q, ptr_d, gnt_id;
    logic [N_REQ-1:0] gnt, req_ready_q, req_ready_d;
    logic [CW-1:0]    cnt_q, cnt_d, hit_q, hit_d, det_out_ext;
    logic [CW-1:0]    res_count_q, res_count_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic             det_rst_q, det_rst_d, det_in_q, det_in_d;
    logic             res_valid_q, res_valid_d;

    rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .id_o  (gnt_id)
    );

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) word_sel = req_data[i*W +: W];
        end
    end

    assign det_out_ext = {{(CW-1){1'b0}}, det_out};

    // Bit timer is a down-counter loaded with W-1; the first SHIFT cycle
    // (count still at its load value) has no meaningful detector sample yet.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        hit_d       = hit_q;
        req_ready_d = '0;
        det_in_d    = 1'b0;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_count_d = res_count_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready_d = gnt;
                    word_d      = word_sel;
                    id_d        = gnt_id;
                    state_d     = CLR;
                end
            end
            CLR: begin
                cnt_d    = CW'(W - 1);
                hit_d    = '0;
                det_in_d = word_q[W-1];
                word_d   = word_q << 1;
                state_d  = SHIFT;
            end
            SHIFT: begin
                if (cnt_q != CW'(W - 1)) hit_d = hit_q + det_out_ext;
                if (cnt_q == '0) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    det_in_d = word_q[W-1];
                    word_d   = word_q << 1;
                end
            end
            DRAIN: begin
                res_count_d = hit_q + det_out_ext;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    ptr_d   = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d = IDLE;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Detector only runs while bits are in flight; it idles in reset.
        det_rst_d = !((state_d == SHIFT) || (state_d == DRAIN));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            id_q        <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            hit_q       <= '0;
            req_ready_q <= '0;
            det_rst_q   <= 1'b1;
            det_in_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            req_ready_q <= req_ready_d;
            det_rst_q   <= det_rst_d;
            det_in_q    <= det_in_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_count_q <= res_count_d;
        end
    end

    assign req_ready = req_ready_q;
    assign det_rst   = det_rst_q;
    assign det_in    = det_in_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_count = res_count_q;

endmodule

// File: tb/tb_moore_det_scheduler.sv
// ----------------------------------------------------------------------------
// tb_moore_det_scheduler
// Drives moore_det_scheduler with a real "11" Moore detector (non-overlapping)
// on det_rst/det_in/det_out. A transaction-timeline model predicts every
// output each cycle; directed tests pin latency, ids, counts and arbitration.
// Honours SCHED_PRIO_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_moore_det_scheduler;

    localparam int N_REQ = 2;
    localparam int W     = 8;
    localparam int IDW   = 1;
    localparam int CW    = 4;
    localparam int LAT   = W + 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [N_REQ-1:0]   req_valid = '0;
    logic [N_REQ*W-1:0] req_data = '0;
    logic [N_REQ-1:0]   req_ready;
    logic               det_rst, det_in, det_out;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [IDW-1:0]     res_id;
    logic [CW-1:0]      res_count;

    int n_cmp = 0;
    int n_mis = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    moore_det_scheduler #(.N_REQ(N_REQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .det_rst   (det_rst),
        .det_in    (det_in),
        .det_out   (det_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_count (res_count)
    );

    // Moore "11" detector: 0 = nothing, 1 = seen one 1, 2 = seen 11 (out high).
    // After a hit the next 1 starts a fresh pair.
    logic [1:0] ds;
    always_ff @(posedge clk or posedge det_rst) begin
        if (det_rst) ds <= 2'd0;
        else if (ds == 2'd1) ds <= det_in ? 2'd2 : 2'd0;
        else ds <= det_in ? 2'd1 : 2'd0;
    end
    assign det_out = (ds == 2'd2);

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Number of high detector samples for a word: count disjoint "11" pairs MSB first.
    function automatic int hits(input logic [W-1:0] w);
        int run = 0;
        int h = 0;
        int wi = int'(w);
        for (int k = W - 1; k >= 0; k--) begin
            if (((wi >> k) & 1) == 1) begin
                if (run == 1) begin h++; run = 0; end
                else run = 1;
            end else begin
                run = 0;
            end
        end
        return h;
    endfunction

    function automatic int pick(input int v, input int ptr);
`ifdef SCHED_PRIO_EN
        for (int i = 0; i < N_REQ; i++) if (((v >> i) & 1) == 1) return i;
        if (ptr < 0) return -2;
`else
        for (int off = 0; off < N_REQ; off++)
            if (((v >> ((ptr + off) % N_REQ)) & 1) == 1) return (ptr + off) % N_REQ;
`endif
        return -1;
    endfunction

    // Timeline model: a grant at cycle s gives req_ready in s, bits in s+1..s+W,
    // detector out of reset s+1..s+W+1, result from s+W+2 until accepted.
    int cyc = 0;
    int m_busy = 0;
    int m_start = 0;
    int m_id = 0;
    int m_ptr = 0;
    int m_count = 0;
    logic [W-1:0] m_word = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            m_busy <= 0;
            m_ptr  <= 0;
        end else if (m_busy == 0) begin
            if (req_valid != '0) begin
                m_id    <= pick(int'(req_valid), m_ptr);
                m_word  <= W'(req_data >> (pick(int'(req_valid), m_ptr) * W));
                m_count <= hits(W'(req_data >> (pick(int'(req_valid), m_ptr) * W)));
                m_start <= cyc + 1;
                m_busy  <= 1;
            end
        end else if ((cyc - m_start >= W + 2) && res_ready) begin
            m_busy <= 0;
            m_ptr  <= (m_id + 1) % N_REQ;
        end
    end

    int p, e_rr, e_drst, e_din, e_rv;
    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst) begin
                chk("rst_req_ready", int'(req_ready), 0);
                chk("rst_det_rst", int'(det_rst), 1);
                chk("rst_det_in", int'(det_in), 0);
                chk("rst_res_valid", int'(res_valid), 0);
                chk("rst_res_id", int'(res_id), 0);
                chk("rst_res_count", int'(res_count), 0);
            end else begin
                p      = cyc - m_start;
                e_rr   = (m_busy != 0 && p == 0) ? (1 << m_id) : 0;
                e_drst = (m_busy != 0 && p >= 1 && p <= W + 1) ? 0 : 1;
                e_din  = (m_busy != 0 && p >= 1 && p <= W) ? ((int'(m_word) >> (W - p)) & 1) : 0;
                e_rv   = (m_busy != 0 && p >= W + 2) ? 1 : 0;
                chk("req_ready", int'(req_ready), e_rr);
                chk("det_rst", int'(det_rst), e_drst);
                chk("det_in", int'(det_in), e_din);
                chk("res_valid", int'(res_valid), e_rv);
                if (e_rv == 1) begin
                    chk("res_id", int'(res_id), m_id);
                    chk("res_count", int'(res_count), m_count);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int g);
        int n = 0;
        g = -1;
        while (req_ready == '0 && n < 60) begin step(); n++; end
        chk("ready_seen", int'(req_ready != '0), 1);
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g = i;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!res_valid && lat < 60) begin step(); lat++; end
        chk("result_seen", int'(res_valid), 1);
    endtask

    task automatic set_word(input int id, input logic [W-1:0] word);
        for (int i = 0; i < N_REQ; i++) if (i == id) req_data[i*W +: W] = word;
    endtask

    task automatic run_single(input int id, input logic [W-1:0] word,
                              output int g, output int lat, output int rid, output int rcnt);
        set_word(id, word);
        req_valid = N_REQ'(1 << id);
        wait_ready(g);
        req_valid = '0;
        wait_result(lat);
        rid  = int'(res_id);
        rcnt = int'(res_count);
        step();
    endtask

    int g, lat, rid, rcnt;
    int got[4];
    int exp_g[4];
    logic [W-1:0] hw;

    initial begin
`ifdef SCHED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        rst = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_det_rst", int'(det_rst), 1);
        chk("reset_res_valid", int'(res_valid), 0);
        chk("reset_req_ready", int'(req_ready), 0);
        step();
        rst = 1'b1;
        step();

        chk("model_hits_FF", hits(8'hFF), 4);
        chk("model_hits_C0", hits(8'hC0), 1);
        chk("model_hits_00", hits(8'h00), 0);
        chk("model_hits_B6", hits(8'hB6), 2);

        run_single(0, 8'hFF, g, lat, rid, rcnt);
        chk("ff_grant", g, 0);
        chk("ff_latency", lat, LAT);
        chk("ff_id", rid, 0);
        chk("ff_count", rcnt, 4);

        run_single(1, 8'hC0, g, lat, rid, rcnt);
        chk("c0_grant", g, 1);
        chk("c0_id", rid, 1);
        chk("c0_count", rcnt, 1);

        run_single(0, 8'h00, g, lat, rid, rcnt);
        chk("00_id", rid, 0);
        chk("00_count", rcnt, 0);

        // Arbitration from a fresh reset with both requesters always valid.
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        req_data = 16'hA55A;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ready(g);
            got[k] = g;
            step();
        end
        req_valid = '0;
        repeat (W + 4) step();
        for (int k = 0; k < 4; k++) chk($sformatf("grant_%0d", k), got[k], exp_g[k]);

        // Result held while the consumer stalls; other requests must wait.
        res_ready = 1'b0;
        hw = 8'h6F;
        set_word(0, hw);
        req_valid = 2'b01;
        wait_ready(g);
        req_valid = 2'b11;
        wait_result(lat);
        rid  = int'(res_id);
        rcnt = int'(res_count);
        chk("hold_count", rcnt, 3);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_valid", int'(res_valid), 1);
            chk("hold_id", int'(res_id), rid);
            chk("hold_cnt", int'(res_count), rcnt);
            chk("hold_no_ready", int'(req_ready), 0);
        end
        req_valid = '0;
        res_ready = 1'b1;
        repeat (3) step();

        // Reset in the middle of shifting aborts the word.
        run_single(0, 8'hFF, g, lat, rid, rcnt);
        set_word(0, 8'hFF);
        req_valid = 2'b01;
        wait_ready(g);
        req_valid = '0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_det_rst", int'(det_rst), 1);
        chk("abort_res_valid", int'(res_valid), 0);
        chk("abort_det_in", int'(det_in), 0);
        step();
        step();
        rst = 1'b1;
        repeat (3) step();
        chk("abort_no_ready", int'(req_ready), 0);
        run_single(0, 8'hFF, g, lat, rid, rcnt);
        chk("after_abort_latency", lat, LAT);
        chk("after_abort_count", rcnt, 4);

        // Randomised traffic, valids and consumer stalls.
        repeat (1500) begin
            step();
            req_valid = N_REQ'($urandom_range(0, 3));
            req_data  = (N_REQ*W)'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        res_ready = 1'b1;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_mis);
        $fatal(1, "watchdog expired");
    end

endmodule
